// File: rtl/dm_pkg.sv
// dm_pkg: shared codes for the data-memory responder.
//   - load control codes (LD_*), 3 bits, as driven on req_load_ctrl
//   - store control codes (SV_*), 2 bits, as driven on req_save_ctrl
//   - FSM state encodings for the responder (CLEAR, IDLE, WAIT, RESP)
package dm_pkg;

   localparam logic [2:0] LD_NONE = 3'd0;
   localparam logic [2:0] LD_LB   = 3'd1;
   localparam logic [2:0] LD_LBU  = 3'd2;
   localparam logic [2:0] LD_LH   = 3'd3;
   localparam logic [2:0] LD_LHU  = 3'd4;
   localparam logic [2:0] LD_LW   = 3'd5;

   localparam logic [1:0] SV_NONE = 2'd0;
   localparam logic [1:0] SV_SB   = 2'd1;
   localparam logic [1:0] SV_SH   = 2'd2;
   localparam logic [1:0] SV_SW   = 2'd3;

   // Responder FSM states.
   localparam logic [1:0] CLEAR = 2'd0;
   localparam logic [1:0] IDLE  = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

endpackage

// File: rtl/dm_lane_unit.sv
// dm_lane_unit: combinational byte-lane logic for one 32-bit memory word.
//   oldWord    in   32  current contents of the addressed word
//   wdata      in   32  right-aligned store data
//   lane       in   2   byte offset within the word (addr[1:0])
//   loadCtrl   in   3   LD_* code
//   saveCtrl   in   2   SV_* code
//   mergedWord out  32  oldWord with the store lanes replaced
//   loadData   out  32  extracted and sign/zero-extended load data (0 when no load)
//   alignErr   out  1   half access on odd byte, or word access not on lane 0
module dm_lane_unit
   import dm_pkg::*;
(
   input  logic [31:0] oldWord,
   input  logic [31:0] wdata,
   input  logic [1:0]  lane,
   input  logic [2:0]  loadCtrl,
   input  logic [1:0]  saveCtrl,
   output logic [31:0] mergedWord,
   output logic [31:0] loadData,
   output logic        alignErr
);

   logic [7:0]  byteVal;
   logic [15:0] halfVal;
   logic        halfAccess;
   logic        wordAccess;

   always_comb begin
      byteVal = oldWord[7:0];
      case (lane)
         2'd1:    byteVal = oldWord[15:8];
         2'd2:    byteVal = oldWord[23:16];
         2'd3:    byteVal = oldWord[31:24];
         default: byteVal = oldWord[7:0];
      endcase
      // Half selection uses lane[1] only; odd lanes are caught by alignErr.
      halfVal = lane[1] ? oldWord[31:16] : oldWord[15:0];
   end

   always_comb begin
      mergedWord = oldWord;
      case (saveCtrl)
         SV_SB: begin
            case (lane)
               2'd1:    mergedWord[15:8]  = wdata[7:0];
               2'd2:    mergedWord[23:16] = wdata[7:0];
               2'd3:    mergedWord[31:24] = wdata[7:0];
               default: mergedWord[7:0]   = wdata[7:0];
            endcase
         end
         SV_SH: begin
            if (lane[1]) mergedWord[31:16] = wdata[15:0];
            else         mergedWord[15:0]  = wdata[15:0];
         end
         SV_SW:   mergedWord = wdata;
         default: mergedWord = oldWord;
      endcase
   end

   always_comb begin
      loadData = '0;
      case (loadCtrl)
         LD_LB:   loadData = {{24{byteVal[7]}}, byteVal};
         LD_LBU:  loadData = {24'd0, byteVal};
         LD_LH:   loadData = {{16{halfVal[15]}}, halfVal};
         LD_LHU:  loadData = {16'd0, halfVal};
         LD_LW:   loadData = oldWord;
         default: loadData = '0;
      endcase
   end

   always_comb begin
      halfAccess = (loadCtrl == LD_LH) || (loadCtrl == LD_LHU) || (saveCtrl == SV_SH);
      wordAccess = (loadCtrl == LD_LW) || (saveCtrl == SV_SW);
      alignErr   = (halfAccess && lane[0]) || (wordAccess && (lane != 2'd0));
   end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: memory-side responder for MEM-stage load/store requests.
//   Accepts one request at a time, answers LATENCY cycles after acceptance with a
//   one-cycle resp_valid pulse. After every reset the array is swept to zero
//   (DEPTH cycles) before the first request is accepted.
//   Handshake: a request transfers on a rising edge where req_valid && req_ready.
//   req_ready is high only in IDLE; inputs are latched at acceptance so the issuer may
//   change them afterwards. Responses have no backpressure.
// Ports:
//   clk            in   1   clock, rising edge
//   reset          in   1   asynchronous active-low reset
//   req_valid      in   1   request present
//   req_ready      out 1   responder can accept this cycle
//   req_pc         in   32  issuing PC (store trace only)
//   req_addr       in   32  byte address
//   req_wdata      in   32  right-aligned store data
//   req_load_ctrl  in   3   LD_* code
//   req_save_ctrl  in   2   SV_* code
//   resp_valid     out  1   one-cycle response pulse
//   resp_rdata     out  32  extended load data, 0 for stores/errors
//   resp_err       out  1   request rejected
//   dbgState       out  2   current FSM state (CLEAR/IDLE/WAIT/RESP)
module dm_responder
   import dm_pkg::*;
#(
   parameter int DEPTH   = 4096,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_pc,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_load_ctrl,
   input  logic [1:0]  req_save_ctrl,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [1:0]  dbgState
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   logic [1:0]    state;
   logic [AW-1:0] clrIdx;
   logic [CW-1:0] cnt;

   logic [31:0] pcQ;
   logic [31:0] addrQ;
   logic [31:0] wdataQ;
   logic [2:0]  loadQ;
   logic [1:0]  saveQ;

   logic        respValidQ;
   logic [31:0] respRdataQ;
   logic        respErrQ;

   logic [31:0] mem [DEPTH];

   logic        accept;
   logic        enterResp;
   logic        storeCommit;
   logic [31:0] selPc;
   logic [31:0] selAddr;
   logic [31:0] selWdata;
   logic [2:0]  selLoad;
   logic [1:0]  selSave;
   logic [AW-1:0] wordIdx;
   logic [31:0] oldWord;
   logic [31:0] mergedWord;
   logic [31:0] loadData;
   logic        alignErr;
   logic        rangeErr;
   logic        ctrlErr;
   logic        reqErr;

   assign accept = (state == IDLE) && req_valid;

   // With LATENCY==1 the response is produced at the accepting edge itself, so the
   // lane/error logic must see the live request rather than the latches.
   always_comb begin
      if (state == IDLE) begin
         selPc    = req_pc;
         selAddr  = req_addr;
         selWdata = req_wdata;
         selLoad  = req_load_ctrl;
         selSave  = req_save_ctrl;
      end else begin
         selPc    = pcQ;
         selAddr  = addrQ;
         selWdata = wdataQ;
         selLoad  = loadQ;
         selSave  = saveQ;
      end
   end

   assign wordIdx = selAddr[AW+1:2];
   assign oldWord = mem[wordIdx];

   dm_lane_unit u_lane (
      .oldWord    (oldWord),
      .wdata      (selWdata),
      .lane       (selAddr[1:0]),
      .loadCtrl   (selLoad),
      .saveCtrl   (selSave),
      .mergedWord (mergedWord),
      .loadData   (loadData),
      .alignErr   (alignErr)
   );

   always_comb begin
      rangeErr = |selAddr[31:AW+2];
      ctrlErr  = (selLoad > LD_LW)
               || ((selLoad != LD_NONE) && (selSave != SV_NONE))
               || ((selLoad == LD_NONE) && (selSave == SV_NONE));
      reqErr   = alignErr || rangeErr || ctrlErr;
   end

   always_comb begin
      enterResp = (accept && (LATENCY == 1))
               || ((state == WAIT) && (cnt == CW'(1)));
      storeCommit = enterResp && !reqErr && (selSave != SV_NONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= CLEAR;
         clrIdx     <= '0;
         cnt        <= '0;
         pcQ        <= '0;
         addrQ      <= '0;
         wdataQ     <= '0;
         loadQ      <= LD_NONE;
         saveQ      <= SV_NONE;
         respValidQ <= 1'b0;
         respRdataQ <= '0;
         respErrQ   <= 1'b0;
      end else begin
         respValidQ <= 1'b0;
         respRdataQ <= '0;
         respErrQ   <= 1'b0;
         case (state)
            CLEAR: begin
               // clrIdx wraps back to 0 so a later reset restarts cleanly.
               clrIdx <= clrIdx + 1'b1;
               if (clrIdx == AW'(DEPTH - 1)) state <= IDLE;
            end
            IDLE: begin
               if (accept) begin
                  pcQ    <= req_pc;
                  addrQ  <= req_addr;
                  wdataQ <= req_wdata;
                  loadQ  <= req_load_ctrl;
                  saveQ  <= req_save_ctrl;
                  cnt    <= CW'(LATENCY - 1);
                  state  <= (LATENCY > 1) ? WAIT : RESP;
               end
            end
            WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) state <= RESP;
            end
            RESP: state <= IDLE;
            default: state <= CLEAR;
         endcase
         if (enterResp) begin
            respValidQ <= 1'b1;
            respErrQ   <= reqErr;
            respRdataQ <= reqErr ? 32'd0 : loadData;
         end
      end
   end

   // Array write port: zero sweep during CLEAR, otherwise the committed store.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[clrIdx] <= '0;
      end else if (storeCommit) begin
         mem[wordIdx] <= mergedWord;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (reset && storeCommit)
         $display("%d@%h: *%h <= %h", $time, selPc, {selAddr[31:2], 2'b00}, mergedWord);
   end
`endif

   assign req_ready  = (state == IDLE);
   assign resp_valid = respValidQ;
   assign resp_rdata = respRdataQ;
   assign resp_err   = respErrQ;
   assign dbgState   = state;

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;
  import dm_pkg::*;

  localparam int DEPTH   = 16;
  localparam int LATENCY = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_pc = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_load_ctrl = '0;
  logic [1:0]  req_save_ctrl = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  dbg_state;

  dm_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_pc        (req_pc),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_load_ctrl (req_load_ctrl),
    .req_save_ctrl (req_save_ctrl),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .dbgState      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;
  logic [32:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [32:0] mon_exp;
  int          mon_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Responses are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset && resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 64'(resp_valid), 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        check("resp_err_data", 64'({resp_err, resp_rdata}), 64'(mon_exp));
        check("resp_latency", 64'(cyc), 64'(mon_cyc));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Waits (bounded) for req_ready on a falling edge, drives the request and returns
  // just after the accepting rising edge with req_valid still high.
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] ld, input logic [1:0] sv,
                       input logic exp_err, input logic [31:0] exp_data,
                       input bit track, output int waits);
    waits = 0;
    @(negedge clk);
    while (!req_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!req_ready) begin
      check("ready_timeout", 64'(req_ready), 64'd1);
      return;
    end
    req_pc        = $urandom;
    req_addr      = addr;
    req_wdata     = wdata;
    req_load_ctrl = ld;
    req_save_ctrl = sv;
    req_valid     = 1'b1;
    if (track) begin
      exp_q.push_back({exp_err, exp_data});
      exp_cyc_q.push_back(cyc + LATENCY);
    end
    @(posedge clk);
  endtask

  task automatic drop();
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic req(input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] ld, input logic [1:0] sv,
                     input logic exp_err, input logic [31:0] exp_data);
    int w;
    issue(addr, wdata, ld, sv, exp_err, exp_data, 1'b1, w);
    drop();
  endtask

  // Releases reset on a falling edge and counts cycles with req_ready low.
  task automatic release_and_count(output int lows);
    reset = 1'b1;
    lows = 0;
    while (!req_ready && lows < 100) begin
      lows++;
      @(negedge clk);
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] rv [4];

  initial begin
    int w;
    repeat (3) @(negedge clk);
    check("rst_req_ready",  64'(req_ready),  64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    check("rst_resp_err",   64'(resp_err),   64'd0);
    check("rst_state",      64'(dbg_state),  64'(CLEAR));

    // A store held valid during the sweep must be ignored.
    req_addr = 32'h0; req_wdata = 32'hDEADBEEF;
    req_load_ctrl = LD_NONE; req_save_ctrl = SV_SW; req_valid = 1'b1;
    release_and_count(w);
    req_valid = 1'b0;
    check("clear_cycles", 64'(w), 64'd16);

    for (int i = 0; i < DEPTH; i++)
      req(32'(i * 4), 32'h0, LD_LW, SV_NONE, 1'b0, 32'h0);

    // Word store / load.
    req(32'h8, 32'h12345678, LD_NONE, SV_SW, 1'b0, 32'h0);
    req(32'h8, 32'h0, LD_LW, SV_NONE, 1'b0, 32'h12345678);

    // Byte store with junk in the upper wdata bits.
    req(32'h5, 32'h12345680, LD_NONE, SV_SB, 1'b0, 32'h0);
    req(32'h5, 32'h0, LD_LB,  SV_NONE, 1'b0, 32'hFFFFFF80);
    req(32'h5, 32'h0, LD_LBU, SV_NONE, 1'b0, 32'h00000080);
    req(32'h4, 32'h0, LD_LW,  SV_NONE, 1'b0, 32'h00008000);

    // Half store to the upper half of word 0.
    req(32'h2, 32'h5555BEEF, LD_NONE, SV_SH, 1'b0, 32'h0);
    req(32'h2, 32'h0, LD_LH,  SV_NONE, 1'b0, 32'hFFFFBEEF);
    req(32'h2, 32'h0, LD_LHU, SV_NONE, 1'b0, 32'h0000BEEF);

    // Error cases; none of them may write.
    req(32'h3,  32'h00001111, LD_NONE, SV_SH,   1'b1, 32'h0);
    req(32'h0,  32'h0,        LD_LW,   SV_NONE, 1'b0, 32'hBEEF0000);
    req(32'h40, 32'h0,        LD_LW,   SV_NONE, 1'b1, 32'h0);
    req(32'h40, 32'hAAAAAAAA, LD_NONE, SV_SW,   1'b1, 32'h0);
    req(32'h2,  32'h0,        LD_LW,   SV_NONE, 1'b1, 32'h0);
    req(32'h1,  32'h0,        LD_LHU,  SV_NONE, 1'b1, 32'h0);
    req(32'h0,  32'h0,        3'd6,    SV_NONE, 1'b1, 32'h0);
    req(32'h0,  32'h0,        LD_NONE, SV_NONE, 1'b1, 32'h0);
    req(32'h0,  32'hFFFFFFFF, LD_LW,   SV_SW,   1'b1, 32'h0);
    req(32'h0,  32'h0,        LD_LW,   SV_NONE, 1'b0, 32'hBEEF0000);

    // Random words into the top of the array, then read back.
    for (int i = 0; i < 4; i++) begin
      rv[i] = $urandom;
      req(32'h30 + 32'(i * 4), rv[i], LD_NONE, SV_SW, 1'b0, 32'h0);
    end
    for (int i = 0; i < 4; i++)
      req(32'h30 + 32'(i * 4), 32'h0, LD_LW, SV_NONE, 1'b0, rv[i]);

    // Back-to-back with req_valid held high: two not-ready cycles between accepts.
    issue(32'h8, 32'h0, LD_LW, SV_NONE, 1'b0, 32'h12345678, 1'b1, w);
    issue(32'h4, 32'h0, LD_LW, SV_NONE, 1'b0, 32'h00008000, 1'b1, w);
    check("b2b_gap1", 64'(w), 64'd2);
    issue(32'h0, 32'h0, LD_LW, SV_NONE, 1'b0, 32'hBEEF0000, 1'b1, w);
    check("b2b_gap2", 64'(w), 64'd2);
    issue(32'h5, 32'h0, LD_LBU, SV_NONE, 1'b0, 32'h00000080, 1'b1, w);
    check("b2b_gap3", 64'(w), 64'd2);
    drop();

    // Reset while a store is in WAIT: dropped, sweep reruns.
    req(32'h0, 32'hA5A5A5A5, LD_NONE, SV_SW, 1'b0, 32'h0);
    req(32'h0, 32'h0, LD_LW, SV_NONE, 1'b0, 32'hA5A5A5A5);
    issue(32'h0, 32'h11111111, LD_NONE, SV_SW, 1'b0, 32'h0, 1'b0, w);
    @(negedge clk);
    check("mid_state_wait", 64'(dbg_state), 64'(WAIT));
    reset = 1'b0;
    req_valid = 1'b0;
    #1;
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    check("mid_rst_valid", 64'(resp_valid), 64'd0);
    repeat (3) @(negedge clk);
    release_and_count(w);
    check("clear_rerun_cycles", 64'(w), 64'd16);
    req(32'h0, 32'h0, LD_LW, SV_NONE, 1'b0, 32'h0);
    req(32'h8, 32'h0, LD_LW, SV_NONE, 1'b0, 32'h0);
    req(32'h3C, 32'h0, LD_LW, SV_NONE, 1'b0, 32'h0);

    // Drain outstanding expectations.
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
